life_matrix_driver: RTL
=======================

# life_matrix_driver

Display end of the Game grid interface: consumes the 64-bit generation word produced by the Game block and scans it row by row onto an 8x8 LED matrix. Double-buffered, so a new generation arriving mid-frame is displayed only from the next frame boundary, with no tearing. Sits between the Game core's grid output and the board's row/column pins.

## Interface
- DWELL, 4: cycles each row is driven (must be >= 1)
- BLANK, 1: cycles all rows are off between rows (0 allowed)
- clk  in  1  system clock, rising edge
- flopreset  in  1  synchronous, active-low reset
- grid_in  in  64  generation word; cell (r,c) = grid_in[63-8r-c], row 0 = bits 63:56, col 0 = MSB
- grid_valid  in  1  one-cycle strobe: grid_in holds a new generation
- row_sel  out  8  one-hot row enable, bit r = row r, active high
- col_data  out  8  column data for the selected row, bit 7 = col 0
- frame_done  out  1  one-cycle pulse at the end of each full frame
- overrun  out  1  sticky: a generation was overwritten before display
- pop_count  out  7  live cells in the displayed grid (only with LIFE_POPCOUNT_EN)

## Operation
- Registers: active buffer (displayed), shadow buffer, pending flag, row index 0..7, phase counter, state.
- States: IDLE (no grid yet), SCAN (row driven), BLANK (all rows off).
- IDLE: outputs 0. grid_valid loads grid_in directly into active, row=0, -> SCAN.
- SCAN: row_sel = 1<<row, col_data = active row slice. After DWELL cycles -> BLANK (or, if BLANK=0, -> next row's SCAN).
- BLANK: row_sel=0, col_data=0 for BLANK cycles; then row+1 -> SCAN.
- Frame end = end of row 7's phase (BLANK, or SCAN if BLANK=0): frame_done=1 for that cycle; row wraps to 0; if pending, active<=shadow and pending<=0.
- grid_valid in SCAN/BLANK: shadow<=grid_in, pending<=1. If pending was already 1: overrun<=1 (last write wins).
- grid_valid in the frame-end cycle: active<=grid_in directly, pending<=0, no overrun (the bypass wins over an older shadow).
- Frame length = 8*(DWELL+BLANK) cycles; counter width $clog2(DWELL+BLANK+1).
- Never returns to IDLE except by reset.

## Timing
- All outputs registered. Reset: row_sel=0, col_data=0, frame_done=0, overrun=0, pop_count=0; buffers cleared, pending=0, state IDLE.
- Latency from the IDLE grid_valid at edge t: row_sel=8'h01 and col_data=row 0 valid after edge t+1.
- New generation mid-frame: visible from the first cycle of the next frame's row 0.
- Reset asserted mid-frame: all outputs are 0 on the next edge and the pending grid is discarded.

## Configuration
- LIFE_POPCOUNT_EN defined: pop_count port exists. It is updated on every active-buffer load to the popcount of the loaded grid, and it is valid in the same cycle that row 0 of that grid is first driven.
- Undefined: the port and logic are absent. All other behaviour is identical.

## Structure
- life_pkg: GRID_W=64, ROW_W=8, NUM_ROWS=8, drv_state_t enum {IDLE, SCAN, BLANK}, row-slice function.
- Sub-module life_popcount: combinational 64-bit to 7-bit popcount, instantiated only under LIFE_POPCOUNT_EN.

## Test plan
- Reset, then a single grid_valid with grid_in=64'h0000700000000000, DWELL=4, BLANK=1 -> row 2 shows row_sel=8'h04, col_data=8'h70 for 4 cycles. All other rows show col_data=0. Blank cycles are all-zero. frame_done fires every 40 cycles. pop_count=3.
- In the same setup, at cycle 10 of the frame, grid_valid with 64'hFF00000000000000 -> the current frame is unchanged. The next frame shows row 0 col_data=8'hFF. pop_count=8. overrun=0.
- Two grid_valid strobes within one frame (values A then B) -> B is displayed next frame and overrun=1 stays set until reset.
- grid_valid with 64'h0000000000000001 in the exact frame_done cycle -> the next frame shows row 7 col_data=8'h01. pending is clear and there is no overrun.
- BLANK=0, DWELL=1 -> row_sel steps 01,02,...,80 on consecutive cycles and frame_done fires every 8 cycles.
- flopreset driven low during row 5 -> the next cycle has all outputs 0. No scan occurs until a fresh grid_valid, after which the scan starts at row 0.

Source files
------------

// File: rtl/life_pkg.sv
// life_pkg: shared grid geometry, driver state encoding and row extraction
package life_pkg;
  localparam int GRID_W = 64;
  localparam int ROW_W = 8;
  localparam int NUM_ROWS = 8;
  typedef enum logic [1:0] {IDLE, SCAN, BLANK} drv_state_t;
  function automatic logic [ROW_W-1:0] row_slice(input logic [GRID_W-1:0] g, input logic [2:0] r);
    return g[(NUM_ROWS - 1 - int'(r)) * ROW_W +: ROW_W];
  endfunction
endpackage

// File: rtl/life_matrix_driver_if.sv
// life_matrix_driver_if: grid input and LED matrix outputs; pop_count present with LIFE_POPCOUNT_EN
interface life_matrix_driver_if;
  import life_pkg::*;
  logic [GRID_W-1:0] grid_in;
  logic grid_valid;
  logic [ROW_W-1:0] row_sel;
  logic [ROW_W-1:0] col_data;
  logic frame_done;
  logic overrun;
`ifdef LIFE_POPCOUNT_EN
  logic [6:0] pop_count;
  modport master(output grid_in, grid_valid, input row_sel, col_data, frame_done, overrun, pop_count);
  modport slave(input grid_in, grid_valid, output row_sel, col_data, frame_done, overrun, pop_count);
`else
  modport master(output grid_in, grid_valid, input row_sel, col_data, frame_done, overrun);
  modport slave(input grid_in, grid_valid, output row_sel, col_data, frame_done, overrun);
`endif
endinterface

// File: rtl/life_popcount.sv
// life_popcount: combinational count of live cells in a 64-bit grid
module life_popcount
  import life_pkg::*;
(
  input  logic [GRID_W-1:0] grid,
  output logic [6:0]        count
);
  // sum every cell bit
  always_comb begin
    count = '0;
    for (int i = 0; i < GRID_W; i++) count += 7'(grid[i]);
  end
endmodule

// File: rtl/life_matrix_driver.sv
// life_matrix_driver: double-buffered 8x8 row scanner for Life grids; LIFE_POPCOUNT_EN adds pop_count
module life_matrix_driver #(
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input logic clk,
  input logic flopreset,
  life_matrix_driver_if.slave bus
);
  import life_pkg::*;
  localparam int PW = $clog2(DWELL + BLANK + 1);
  drv_state_t state, state_nx;
  logic [2:0] row, row_nx;
  logic [PW-1:0] phase, phase_nx;
  logic [GRID_W-1:0] active, active_nx, shadow, shadow_nx;
  logic pending, pending_nx, frame_end, ovr_set;
  // scan sequencing plus buffer swap; a strobe in the frame-end cycle bypasses the shadow
  always_comb begin
    state_nx = state;
    row_nx = row;
    phase_nx = phase + 1'b1;
    active_nx = active;
    shadow_nx = shadow;
    pending_nx = pending;
    frame_end = 1'b0;
    ovr_set = 1'b0;
    case (state)
      IDLE: begin
        phase_nx = '0;
        if (bus.grid_valid) begin
          active_nx = bus.grid_in;
          row_nx = '0;
          state_nx = SCAN;
        end
      end
      SCAN: if (phase == PW'(DWELL - 1)) begin
        phase_nx = '0;
        if (BLANK > 0) state_nx = life_pkg::BLANK;
        else begin
          row_nx = row + 1'b1;
          frame_end = row == 3'd7;
        end
      end
      default: if (phase == PW'(BLANK - 1)) begin
        phase_nx = '0;
        state_nx = SCAN;
        row_nx = row + 1'b1;
        frame_end = row == 3'd7;
      end
    endcase
    if (state != IDLE) begin
      if (frame_end && pending) begin
        active_nx = shadow;
        pending_nx = 1'b0;
      end
      if (bus.grid_valid && frame_end) begin
        active_nx = bus.grid_in;
        pending_nx = 1'b0;
      end else if (bus.grid_valid) begin
        shadow_nx = bus.grid_in;
        pending_nx = 1'b1;
        ovr_set = pending;
      end
    end
  end
  // state and buffers, with registered matrix outputs derived from the current row
  always_ff @(posedge clk) begin
    if (!flopreset) begin
      state <= IDLE;
      row <= '0;
      phase <= '0;
      active <= '0;
      shadow <= '0;
      pending <= 1'b0;
      bus.row_sel <= '0;
      bus.col_data <= '0;
      bus.frame_done <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      state <= state_nx;
      row <= row_nx;
      phase <= phase_nx;
      active <= active_nx;
      shadow <= shadow_nx;
      pending <= pending_nx;
      bus.row_sel <= state == SCAN ? 8'b1 << row : '0;
      bus.col_data <= state == SCAN ? row_slice(active, row) : '0;
      bus.frame_done <= frame_end;
      bus.overrun <= bus.overrun | ovr_set;
    end
  end
`ifdef LIFE_POPCOUNT_EN
  logic [6:0] pc;
  life_popcount u_pc (.grid(active), .count(pc));
  // count tracks the active buffer so it lines up with row 0 of a freshly loaded grid
  always_ff @(posedge clk) bus.pop_count <= !flopreset ? '0 : pc;
`endif
endmodule
